// File: rtl/sobel_pkg.sv
// Shared widths, FSM encoding and delay-line tag type for the sobel window controller.
package sobel_pkg;
    localparam int PIX_W         = 8;
    localparam int COL_W         = 10;
    localparam int ROW_W         = 9;
    localparam int SOBEL_LAT_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [COL_W-1:0] x;
        logic [ROW_W-1:0] y;
    } tag_t;
endpackage

// File: rtl/sobel_window_ctrl_if.sv
// Pixel stream, 3x3 window and edge result signals between source, sobel core and controller.
interface sobel_window_ctrl_if;
    import sobel_pkg::*;

    logic             frame_start;
    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] z0, z1, z2, z3, z4, z5, z6, z7, z8;
    logic             win_valid;
    logic [PIX_W-1:0] edge_in;
    logic             edge_valid;
    logic [PIX_W-1:0] edge_pix;
    logic [COL_W-1:0] edge_x;
    logic [ROW_W-1:0] edge_y;
    logic             frame_done;
    logic             overrun;

    modport slave (
        input  frame_start, pix_in, pix_valid, edge_in,
        output pix_ready, z0, z1, z2, z3, z4, z5, z6, z7, z8, win_valid,
               edge_valid, edge_pix, edge_x, edge_y, frame_done, overrun
    );

    modport master (
        output frame_start, pix_in, pix_valid, edge_in,
        input  pix_ready, z0, z1, z2, z3, z4, z5, z6, z7, z8, win_valid,
               edge_valid, edge_pix, edge_x, edge_y, frame_done, overrun
    );
endinterface

// File: rtl/sobel_line_buf.sv
// One line of pixels; read returns the old contents of addr in the same cycle as the write.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);
    logic [PIX_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end
endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster-to-3x3 window sequencer with interior gating, latency tracking and frame control.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int SOBEL_LAT = SOBEL_LAT_DEF
) (
    input logic                clock,
    input logic                reset_n,
    sobel_window_ctrl_if.slave bus
);
    localparam int AW = $clog2(H_ACTIVE);
    localparam int DW = $clog2(SOBEL_LAT + 1) + 1;

    state_t           state_reg, state_next;
    logic [DW-1:0]    drain_reg, drain_next;
    logic [COL_W-1:0] col_reg, col_next, col_eff;
    logic [ROW_W-1:0] row_reg, row_next, row_eff;
    logic             accept, last_pix;
    logic             pix_ready, frame_done_next, overrun_next;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic [PIX_W-1:0] z_reg [9];
    logic [PIX_W-1:0] z_next [9];
    logic [PIX_W-1:0] col_new [3];
    tag_t             win_reg, win_next;
    tag_t             dly_reg [SOBEL_LAT];
    tag_t             dly_in [SOBEL_LAT];
    logic             edge_valid_reg, frame_done_reg, overrun_reg;
    logic [PIX_W-1:0] edge_pix_reg;
    logic [COL_W-1:0] edge_x_reg;
    logic [ROW_W-1:0] edge_y_reg;

    // frame_start forces the coordinates of a coincident pixel to (0,0)
    assign col_eff  = bus.frame_start ? '0 : col_reg;
    assign row_eff  = bus.frame_start ? '0 : row_reg;
    assign accept   = bus.pix_valid && (bus.frame_start || state_reg == ACTIVE);
    assign last_pix = (col_eff == COL_W'(H_ACTIVE - 1)) && (row_eff == ROW_W'(V_ACTIVE - 1));

    sobel_line_buf #(.DEPTH(H_ACTIVE)) lb0 (
        .clock (clock), .we (accept), .addr (col_eff[AW-1:0]),
        .wdata (bus.pix_in), .rdata (lb0_rd)
    );
    sobel_line_buf #(.DEPTH(H_ACTIVE)) lb1 (
        .clock (clock), .we (accept), .addr (col_eff[AW-1:0]),
        .wdata (lb0_rd), .rdata (lb1_rd)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            drain_reg <= drain_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        drain_next = drain_reg;
        if (bus.frame_start) begin
            state_next = ACTIVE;
            drain_next = '0;
        end else begin
            case (state_reg)
                ACTIVE: if (accept && last_pix) begin
                    state_next = DRAIN;
                    drain_next = '0;
                end
                DRAIN: if (drain_reg == DW'(SOBEL_LAT)) begin
                    state_next = IDLE;
                end else begin
                    drain_next = drain_reg + DW'(1);
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        pix_ready       = (state_reg == ACTIVE);
        frame_done_next = !bus.frame_start && state_reg == DRAIN && drain_reg == DW'(SOBEL_LAT);
        overrun_next    = overrun_reg;
        if (bus.frame_start) begin
            overrun_next = 1'b0;
        end else if (bus.pix_valid && !pix_ready) begin
            overrun_next = 1'b1;
        end
    end

    always_comb begin
        col_next = col_eff;
        row_next = row_eff;
        if (accept) begin
            if (col_eff == COL_W'(H_ACTIVE - 1)) begin
                col_next = '0;
                row_next = (row_eff == ROW_W'(V_ACTIVE - 1)) ? '0 : row_eff + ROW_W'(1);
            end else begin
                col_next = col_eff + COL_W'(1);
            end
        end
        win_next.valid = accept && (col_eff >= COL_W'(2)) && (row_eff >= ROW_W'(2));
        win_next.x     = col_eff - COL_W'(1);
        win_next.y     = row_eff - ROW_W'(1);
    end

    assign col_new[0] = lb1_rd;
    assign col_new[1] = lb0_rd;
    assign col_new[2] = bus.pix_in;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
            assign z_next[3*gi]   = accept ? z_reg[3*gi+1] : z_reg[3*gi];
            assign z_next[3*gi+1] = accept ? z_reg[3*gi+2] : z_reg[3*gi+1];
            assign z_next[3*gi+2] = accept ? col_new[gi]   : z_reg[3*gi+2];
        end
        for (genvar gi = 0; gi < SOBEL_LAT; gi++) begin : g_dly
            if (gi == 0) begin : g_head
                assign dly_in[gi] = win_reg;
            end else begin : g_tail
                assign dly_in[gi] = dly_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_reg        <= '0;
            row_reg        <= '0;
            win_reg        <= '0;
            edge_valid_reg <= 1'b0;
            edge_pix_reg   <= '0;
            edge_x_reg     <= '0;
            edge_y_reg     <= '0;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            for (int i = 0; i < 9; i++) z_reg[i] <= '0;
            for (int i = 0; i < SOBEL_LAT; i++) dly_reg[i] <= '0;
        end else begin
            col_reg        <= col_next;
            row_reg        <= row_next;
            win_reg        <= win_next;
            frame_done_reg <= frame_done_next;
            overrun_reg    <= overrun_next;
            for (int i = 0; i < 9; i++) z_reg[i] <= z_next[i];
            // a restart discards every result still in flight from the aborted frame
            for (int i = 0; i < SOBEL_LAT; i++) dly_reg[i] <= bus.frame_start ? '0 : dly_in[i];
            if (bus.frame_start) begin
                edge_valid_reg <= 1'b0;
                edge_pix_reg   <= '0;
                edge_x_reg     <= '0;
                edge_y_reg     <= '0;
            end else begin
                edge_valid_reg <= dly_reg[SOBEL_LAT-1].valid;
                edge_pix_reg   <= dly_reg[SOBEL_LAT-1].valid ? bus.edge_in : '0;
                edge_x_reg     <= dly_reg[SOBEL_LAT-1].x;
                edge_y_reg     <= dly_reg[SOBEL_LAT-1].y;
            end
        end
    end

    assign bus.pix_ready  = pix_ready;
    assign bus.win_valid  = win_reg.valid;
    assign bus.edge_valid = edge_valid_reg;
    assign bus.edge_pix   = edge_pix_reg;
    assign bus.edge_x     = edge_x_reg;
    assign bus.edge_y     = edge_y_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.overrun    = overrun_reg;
    assign bus.z0 = z_reg[0];
    assign bus.z1 = z_reg[1];
    assign bus.z2 = z_reg[2];
    assign bus.z3 = z_reg[3];
    assign bus.z4 = z_reg[4];
    assign bus.z5 = z_reg[5];
    assign bus.z6 = z_reg[6];
    assign bus.z7 = z_reg[7];
    assign bus.z8 = z_reg[8];
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on an 8x6 frame with a 3-stage sobel model attached.
module tb_sobel_window_ctrl;
    import sobel_pkg::*;

    localparam int H = 8;
    localparam int V = 6;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sobel_window_ctrl_if sif();

    sobel_window_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .SOBEL_LAT(3)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (sif.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] sobel_mag(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        int gx, gy, m;
        gx = (a2 + 2*a5 + a8) - (a0 + 2*a3 + a6) + 0*a4;
        gy = (a6 + 2*a7 + a8) - (a0 + 2*a1 + a2);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 8'hFF : 8'(m);
    endfunction

    logic [7:0] s1, s2, s3;
    always @(posedge clock) begin
        s1 <= sobel_mag(int'(sif.z0), int'(sif.z1), int'(sif.z2), int'(sif.z3), int'(sif.z4),
                        int'(sif.z5), int'(sif.z6), int'(sif.z7), int'(sif.z8));
        s2 <= s1;
        s3 <= s2;
    end
    assign sif.edge_in = s3;

    int res_x[$], res_y[$], res_p[$], res_c[$];
    int fd_cnt = 0;
    int fd_cyc = 0;
    always @(negedge clock) begin
        if (sif.edge_valid) begin
            res_x.push_back(int'(sif.edge_x));
            res_y.push_back(int'(sif.edge_y));
            res_p.push_back(int'(sif.edge_pix));
            res_c.push_back(cyc);
        end
        if (sif.frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    int last_acc_cyc = 0;
    int ramp_acc_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int pix_of(input int mode, input int r, input int c);
        if (mode == 0) return 50;
        if (mode == 1) return 10*r + c;
        return (c < 4) ? 0 : 200;
    endfunction

    // first pixel is sent together with frame_start
    task automatic send_pixels(input int mode, input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            int r = i / H;
            int c = i % H;
            sif.frame_start = (i == 0);
            sif.pix_valid   = 1'b1;
            sif.pix_in      = 8'(pix_of(mode, r, c));
            step();
            sif.frame_start = 1'b0;
            last_acc_cyc    = cyc;
            if (mode == 1 && r == 2 && c == 2) begin
                ramp_acc_cyc = cyc;
                chk("ramp_win_valid", 32'(sif.win_valid), 1);
                chk("ramp_z0", 32'(sif.z0), 0);
                chk("ramp_z1", 32'(sif.z1), 1);
                chk("ramp_z2", 32'(sif.z2), 2);
                chk("ramp_z3", 32'(sif.z3), 10);
                chk("ramp_z4", 32'(sif.z4), 11);
                chk("ramp_z5", 32'(sif.z5), 12);
                chk("ramp_z6", 32'(sif.z6), 20);
                chk("ramp_z7", 32'(sif.z7), 21);
                chk("ramp_z8", 32'(sif.z8), 22);
            end
            if (toggle) begin
                sif.pix_valid = 1'b0;
                step();
                chk("toggle_hold_win_valid", 32'(sif.win_valid), 0);
            end
        end
        sif.pix_valid = 1'b0;
    endtask

    task automatic check_frame(input int base, input int mode, input string tag);
        int n, bad_xy, bad_p, ex, ey, ep;
        n = res_x.size() - base;
        chk({tag, "_count"}, 32'(n), 24);
        bad_xy = 0;
        bad_p  = 0;
        for (int k = 0; k < n && k < 24; k++) begin
            ex = 1 + k % 6;
            ey = 1 + k / 6;
            ep = (mode == 0) ? 0 : (mode == 1) ? 88 : ((ex == 3 || ex == 4) ? 255 : 0);
            if (res_x[base+k] != ex || res_y[base+k] != ey) bad_xy++;
            if (res_p[base+k] != ep) bad_p++;
        end
        chk({tag, "_bad_xy"}, 32'(bad_xy), 0);
        chk({tag, "_bad_pix"}, 32'(bad_p), 0);
    endtask

    initial begin
        int base, fdb, t_last;
        sif.frame_start = 1'b0;
        sif.pix_valid   = 1'b0;
        sif.pix_in      = '0;
        repeat (3) step();
        chk("rst_pix_ready", 32'(sif.pix_ready), 0);
        chk("rst_win_valid", 32'(sif.win_valid), 0);
        chk("rst_edge_valid", 32'(sif.edge_valid), 0);
        chk("rst_frame_done", 32'(sif.frame_done), 0);
        chk("rst_overrun", 32'(sif.overrun), 0);
        chk("rst_z4", 32'(sif.z4), 0);
        chk("rst_edge_x", 32'(sif.edge_x), 0);
        reset_n = 1'b1;
        step();

        base = res_x.size(); fdb = fd_cnt;
        send_pixels(0, H*V, 1'b0);
        repeat (8) step();
        check_frame(base, 0, "flat");
        chk("flat_frame_done", 32'(fd_cnt - fdb), 1);
        $display("step flat frame: results=%0d frame_done=%0d", res_x.size() - base, fd_cnt - fdb);

        base = res_x.size();
        send_pixels(1, H*V, 1'b0);
        repeat (8) step();
        chk("ramp_first_latency", (res_x.size() > base) ? 32'(res_c[base] - ramp_acc_cyc) : 32'hFFFF, 4);
        chk("ramp_first_x", (res_x.size() > base) ? 32'(res_x[base]) : 32'hFFFF, 1);
        chk("ramp_first_y", (res_x.size() > base) ? 32'(res_y[base]) : 32'hFFFF, 1);
        check_frame(base, 1, "ramp");
        $display("step ramp frame: results=%0d", res_x.size() - base);

        base = res_x.size();
        send_pixels(2, H*V, 1'b0);
        repeat (8) step();
        check_frame(base, 2, "vstep");
        $display("step vertical edge contiguous: results=%0d", res_x.size() - base);

        base = res_x.size();
        send_pixels(2, H*V, 1'b1);
        repeat (8) step();
        check_frame(base, 2, "vstep_toggle");
        $display("step vertical edge toggled: results=%0d", res_x.size() - base);

        base = res_x.size(); fdb = fd_cnt;
        send_pixels(2, 20, 1'b0);
        send_pixels(2, H*V, 1'b0);
        repeat (8) step();
        check_frame(base, 2, "abort");
        chk("abort_frame_done", 32'(fd_cnt - fdb), 1);
        $display("step abort and restart: results=%0d frame_done=%0d", res_x.size() - base, fd_cnt - fdb);

        base = res_x.size(); fdb = fd_cnt;
        send_pixels(2, H*V, 1'b0);
        t_last = last_acc_cyc;
        sif.pix_valid = 1'b1;
        step();
        sif.pix_valid = 1'b0;
        chk("drain_overrun", 32'(sif.overrun), 1);
        chk("drain_pix_ready", 32'(sif.pix_ready), 0);
        repeat (8) step();
        chk("done_pulses", 32'(fd_cnt - fdb), 1);
        chk("done_cycle", 32'(fd_cyc - t_last), 4);
        chk("last_result_cycle", (res_x.size() > base) ? 32'(res_c[res_c.size()-1] - t_last) : 32'hFFFF, 4);
        chk("overrun_sticky", 32'(sif.overrun), 1);
        sif.frame_start = 1'b1;
        step();
        sif.frame_start = 1'b0;
        chk("overrun_cleared", 32'(sif.overrun), 0);
        chk("active_pix_ready", 32'(sif.pix_ready), 1);
        $display("step frame_done timing: T=%0d done=%0d", t_last, fd_cyc);

        send_pixels(1, 20, 1'b0);
        reset_n = 1'b0;
        #2;
        chk("midrst_win_valid", 32'(sif.win_valid), 0);
        chk("midrst_pix_ready", 32'(sif.pix_ready), 0);
        chk("midrst_z8", 32'(sif.z8), 0);
        chk("midrst_edge_valid", 32'(sif.edge_valid), 0);
        step();
        reset_n = 1'b1;
        step();
        chk("midrst_idle_ready", 32'(sif.pix_ready), 0);
        base = res_x.size(); fdb = fd_cnt;
        send_pixels(1, H*V, 1'b0);
        repeat (8) step();
        check_frame(base, 1, "after_reset");
        chk("after_reset_done", 32'(fd_cnt - fdb), 1);
        $display("step reset mid-frame then frame: results=%0d", res_x.size() - base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
- Sequences a raster pixel stream into the 3x3 window (z0..z8) consumed by the sobel edge datapath.
- Owns two line buffers and the row/column counters, gates interior-only windows, and tracks the sobel pipeline latency.
- Emits edge results with coordinates and a frame-complete pulse; sits between the pixel source and the frame-buffer writer.

Parameters:
- H_ACTIVE, 640, pixels per line (>=3)
- V_ACTIVE, 480, lines per frame (>=3)
- SOBEL_LAT, 3, clock edges from window register update to valid edge result

Ports:
- clock  input  1  single system clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- frame_start  input  1  one-cycle pulse; next accepted pixel is (0,0)
- pix_in  input  8  grey pixel
- pix_valid  input  1  pixel qualifier
- pix_ready  output  1  high in ACTIVE only
- z0..z8  output  8 each  window to sobel; z0/z1/z2 top row left->right, z6/z7/z8 bottom (newest) row
- win_valid  output  1  window registers hold a new interior window
- edge_in  input  8  sobel edge result
- edge_valid  output  1  edge_pix/edge_x/edge_y valid
- edge_pix  output  8  registered copy of edge_in when valid, else 0
- edge_x  output  10  centre column of result
- edge_y  output  9  centre row of result
- frame_done  output  1  one-cycle pulse after the last result of a frame
- overrun  output  1  sticky; pix_valid seen while not ready; cleared by frame_start

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counters 0; delay line cleared. Line buffer contents are don't-care.
- States:
  - IDLE: frame_start -> ACTIVE, counters cleared, overrun cleared.
  - ACTIVE: accept when pix_valid; after pixel (H_ACTIVE-1, V_ACTIVE-1) is accepted -> DRAIN.
  - DRAIN: count SOBEL_LAT+1 cycles, pulse frame_done in the last one, -> IDLE.
  - frame_start in any state: restart ACTIVE, counters to 0, delay line flushed, no frame_done for the aborted frame.
  - frame_start with pix_valid in the same cycle: that pixel is (0,0) of the new frame.
- Accept (ACTIVE and pix_valid), at column col, row row:
  - Read lb0[col] (row-1) and lb1[col] (row-2) old values.
  - Write lb1[col] <= lb0[col] and lb0[col] <= pix_in (read-before-write).
  - Shift the window left: z0<=z1, z1<=z2, z3<=z4, z4<=z5, z6<=z7, z7<=z8.
  - Load the new column: z2<=lb1[col], z5<=lb0[col], z8<=pix_in.
  - col increments and wraps at H_ACTIVE-1 to 0, incrementing row.
- win_valid is registered. It is high the cycle after an accept with row>=2 and col>=2, otherwise 0. Window centre is (col-1, row-1).
- No accept: window holds and win_valid=0. The sobel pipeline free-runs; results are gated only by the delay line.
- Delay line: SOBEL_LAT stages of {valid, x, y} shifted every cycle, input from win_valid and the centre coordinates. edge_valid/edge_x/edge_y are registered from the last stage, with edge_pix<=edge_in in the same cycle. Net: edge_valid rises SOBEL_LAT+1 edges after the window update.
- Output size per frame: (H_ACTIVE-2)*(V_ACTIVE-2) results; x in 1..H_ACTIVE-2, y in 1..V_ACTIVE-2. No border results are produced.
- pix_valid in IDLE or DRAIN: pixel dropped, overrun set.
- Reset mid-frame: immediate return to IDLE; no frame_done.

Decomposition:
- Shared package sobel_pkg:
  - PIX_W=8, COL_W=10, ROW_W=9
  - state enum {IDLE, ACTIVE, DRAIN}
  - SOBEL_LAT default
- One sub-module, sobel_line_buf: H_ACTIVE x 8 single-port read-before-write RAM, instantiated twice (lb0, lb1).

Test Plan (H_ACTIVE=8, V_ACTIVE=6, SOBEL_LAT=3, real sobel attached):
- Flat frame, all pixels 50, contiguous -> exactly 24 edge_valid, all edge_pix=0, x 1..6 within each y 1..4, one frame_done.
- Pixel value = 10*row+col, contiguous -> at the accept of (2,2), the next cycle shows win_valid=1 with z0=0, z1=1, z2=2, z3=10, z4=11, z5=12, z6=20, z7=21, z8=22. edge_valid follows exactly 4 cycles after that accept, with x=1, y=1.
- Vertical step, cols 0-3 = 0 and cols 4-7 = 200 -> edge_pix=FF only at x=3 and x=4 for every y, 00 elsewhere. Identical results with pix_valid toggling 1,0,1,0.
- frame_start after 20 accepted pixels, then a full frame -> no frame_done for the aborted frame, exactly 24 results, coordinates restart at (1,1).
- Last pixel accepted at cycle T -> frame_done single pulse at T+4. pix_valid asserted at T+1 -> overrun=1, pix_ready=0; next frame_start clears overrun.
- reset_n low for 1 cycle mid-frame -> all outputs 0 immediately, state IDLE, subsequent frame_start plus frame gives 24 results.
